// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter feeding a sequence detector.
// Captures pattern/length/repeat count on start, shifts the pattern out
// MSB-first one bit per clock, optionally separating repetitions with idle gaps.
// Every output is a flop; each transition computes the values for the next cycle.
module seq_pattern_gen #(
   parameter  int unsigned PAT_W    = 8,
   parameter  int unsigned CNT_W    = 4,
   parameter  int unsigned GAP_CYC  = 1,
   parameter  bit          IDLE_LVL = 1'b0,
   localparam int unsigned LEN_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len_m1,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic             abort,
   output logic             x,
   output logic             x_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int unsigned GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP,
      DONE
   } state_t;

   state_t           state;
   logic [PAT_W-1:0] pattern_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] idx;
   logic [CNT_W-1:0] rep_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [LEN_W-1:0] len_sat;

   // Clamp the requested length to the widest pattern the shadow register holds
   always_comb begin
      len_sat = len_m1;
      if (len_m1 > LEN_W'(PAT_W - 1)) len_sat = LEN_W'(PAT_W - 1);
   end

   // Transfer FSM; idx always names the bit currently presented on x, so the
   // next bit (or the reload for the next repetition) is selected one cycle early
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         pattern_q   <= '0;
         len_q       <= '0;
         idx         <= '0;
         rep_cnt     <= '0;
         gap_cnt     <= '0;
         x           <= IDLE_LVL;
         x_valid     <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         done        <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  pattern_q   <= pattern;
                  len_q       <= len_sat;
                  rep_cnt     <= repeat_n;
                  idx         <= len_sat;
                  x           <= pattern[len_sat];
                  x_valid     <= 1'b1;
                  frame_start <= 1'b1;
                  busy        <= 1'b1;
                  state       <= SHIFT;
               end
            end
            SHIFT: begin
               if (abort) begin
                  state   <= IDLE;
                  x       <= IDLE_LVL;
                  x_valid <= 1'b0;
                  busy    <= 1'b0;
               end else if (idx != '0) begin
                  idx <= idx - LEN_W'(1);
                  x   <= pattern_q[idx - LEN_W'(1)];
               end else if (rep_cnt != CNT_W'(1)) begin
                  // zero means continuous and is never decremented
                  if (rep_cnt != '0) rep_cnt <= rep_cnt - CNT_W'(1);
                  if (GAP_CYC > 0) begin
                     gap_cnt <= GAP_W'(GAP_LOAD);
                     x       <= IDLE_LVL;
                     x_valid <= 1'b0;
                     state   <= GAP;
                  end else begin
                     idx         <= len_q;
                     x           <= pattern_q[len_q];
                     frame_start <= 1'b1;
                  end
               end else begin
                  x       <= IDLE_LVL;
                  x_valid <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            GAP: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (gap_cnt == '0) begin
                  idx         <= len_q;
                  x           <= pattern_q[len_q];
                  x_valid     <= 1'b1;
                  frame_start <= 1'b1;
                  state       <= SHIFT;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               x       <= IDLE_LVL;
               x_valid <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed checks of seq_pattern_gen with and without an
// inter-repetition gap, including abort, ignored starts, length saturation and
// asynchronous reset. Bit streams are packed cycle 1 in the MSB position.
module tb_seq_pattern_gen;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic [7:0] pattern = '0;
   logic [2:0] len_m1 = '0;
   logic [3:0] repeat_n = '0;
   logic       abort = 1'b0;
   logic       xa, va, fa, ba, da;
   logic       xb, vb, fb, bb, db;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] xs, vs, fs, bs, ds;

   always #5 clk = ~clk;

   seq_pattern_gen #(.PAT_W(8), .CNT_W(4), .GAP_CYC(1), .IDLE_LVL(1'b0)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .pattern(pattern),
      .len_m1(len_m1), .repeat_n(repeat_n), .abort(abort),
      .x(xa), .x_valid(va), .frame_start(fa), .busy(ba), .done(da)
   );

   seq_pattern_gen #(.PAT_W(6), .CNT_W(4), .GAP_CYC(0), .IDLE_LVL(1'b0)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .pattern(pattern[5:0]),
      .len_m1(len_m1), .repeat_n(repeat_n), .abort(abort),
      .x(xb), .x_valid(vb), .frame_start(fb), .busy(bb), .done(db)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Pulse start on one instance, then record n cycles of outputs; at cycle
   // poke_cyc either raise abort or re-request start with altered inputs.
   task automatic run_frame(input bit sel_b, input int n, input int poke_cyc, input bit poke_abort,
                            output logic [31:0] ox, output logic [31:0] ov, output logic [31:0] of,
                            output logic [31:0] ob, output logic [31:0] od);
      ox = '0; ov = '0; of = '0; ob = '0; od = '0;
      @(negedge clk);
      if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         start_b = 1'b0;
         abort   = 1'b0;
         if (sel_b) begin
            ox = {ox[30:0], xb}; ov = {ov[30:0], vb}; of = {of[30:0], fb};
            ob = {ob[30:0], bb}; od = {od[30:0], db};
         end else begin
            ox = {ox[30:0], xa}; ov = {ov[30:0], va}; of = {of[30:0], fa};
            ob = {ob[30:0], ba}; od = {od[30:0], da};
         end
         if (c == poke_cyc) begin
            if (poke_abort) abort = 1'b1;
            else begin
               if (sel_b) start_b = 1'b1; else start_a = 1'b1;
               pattern  = 8'h5A;
               len_m1   = 3'd1;
               repeat_n = 4'd0;
            end
         end
      end
      start_a = 1'b0;
      start_b = 1'b0;
      abort   = 1'b0;
   endtask

   initial begin
      #12;
      check_eq("reset_a", {31'd0, xa, va, fa, ba, da}, 32'd0);
      check_eq("reset_b", {31'd0, xb, vb, fb, bb, db}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // single repetition, start during DONE must be ignored
      pattern = 8'b0000_1101; len_m1 = 3'd3; repeat_n = 4'd1;
      run_frame(1'b0, 7, 5, 1'b0, xs, vs, fs, bs, ds);
      check_eq("single_x", xs, 32'b1101000);
      check_eq("single_valid", vs, 32'b1111000);
      check_eq("single_frame", fs, 32'b1000000);
      check_eq("single_busy", bs, 32'b1111100);
      check_eq("single_done", ds, 32'b0000100);

      // two repetitions with one gap cycle
      pattern = 8'b0000_1101; len_m1 = 3'd3; repeat_n = 4'd2;
      run_frame(1'b0, 11, 0, 1'b0, xs, vs, fs, bs, ds);
      check_eq("gap_x", xs, 32'b11010110100);
      check_eq("gap_valid", vs, 32'b11110111100);
      check_eq("gap_frame", fs, 32'b10000100000);
      check_eq("gap_busy", bs, 32'b11111111110);
      check_eq("gap_done", ds, 32'b00000000010);

      // back-to-back repetitions, no gap
      pattern = 8'b0000_0100; len_m1 = 3'd2; repeat_n = 4'd3;
      run_frame(1'b1, 11, 0, 1'b0, xs, vs, fs, bs, ds);
      check_eq("b2b_x", xs, 32'b10010010000);
      check_eq("b2b_valid", vs, 32'b11111111100);
      check_eq("b2b_frame", fs, 32'b10010010000);
      check_eq("b2b_busy", bs, 32'b11111111110);
      check_eq("b2b_done", ds, 32'b00000000010);

      // continuous mode, abort after the 10th bit
      pattern = 8'b0000_1101; len_m1 = 3'd3; repeat_n = 4'd0;
      run_frame(1'b0, 13, 12, 1'b1, xs, vs, fs, bs, ds);
      check_eq("cont_x", xs, 32'b1101011010110);
      check_eq("cont_valid", vs, 32'b1111011110110);
      check_eq("cont_frame", fs, 32'b1000010000100);
      check_eq("cont_busy", bs, 32'b1111111111110);
      check_eq("cont_done", ds, 32'd0);

      // start plus input changes while busy: transfer unaffected
      pattern = 8'b0000_1101; len_m1 = 3'd3; repeat_n = 4'd1;
      run_frame(1'b0, 7, 2, 1'b0, xs, vs, fs, bs, ds);
      check_eq("busy_start_x", xs, 32'b1101000);
      check_eq("busy_start_busy", bs, 32'b1111100);
      check_eq("busy_start_done", ds, 32'b0000100);

      // start together with abort in IDLE: nothing happens
      pattern = 8'b0000_1101; len_m1 = 3'd3; repeat_n = 4'd1;
      @(negedge clk);
      start_a = 1'b1; abort = 1'b1;
      @(negedge clk);
      start_a = 1'b0; abort = 1'b0;
      check_eq("start_abort_c1", {30'd0, ba, va}, 32'd0);
      @(negedge clk);
      check_eq("start_abort_c2", {30'd0, ba, va}, 32'd0);

      // one-bit pattern, two repetitions
      pattern = 8'h01; len_m1 = 3'd0; repeat_n = 4'd2;
      run_frame(1'b0, 5, 0, 1'b0, xs, vs, fs, bs, ds);
      check_eq("len0_x", xs, 32'b10100);
      check_eq("len0_valid", vs, 32'b10100);
      check_eq("len0_frame", fs, 32'b10100);
      check_eq("len0_busy", bs, 32'b11110);
      check_eq("len0_done", ds, 32'b00010);

      // length beyond a 6-bit pattern saturates to 6 bits
      pattern = 8'b0010_1100; len_m1 = 3'd7; repeat_n = 4'd1;
      run_frame(1'b1, 8, 0, 1'b0, xs, vs, fs, bs, ds);
      check_eq("sat_x", xs, 32'b10110000);
      check_eq("sat_valid", vs, 32'b11111100);
      check_eq("sat_done", ds, 32'b00000010);

      // asynchronous reset in the middle of a shift
      pattern = 8'b0000_1101; len_m1 = 3'd3; repeat_n = 4'd0;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      check_eq("pre_reset_valid", {31'd0, va}, 32'd1);
      #2 reset_n = 1'b0;
      #1 check_eq("async_reset", {27'd0, xa, va, fa, ba, da}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_eq("post_reset_idle", {30'd0, ba, va}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
